// File: rtl/pcm_2_pdm.sv
// pcm_2_pdm: first-order delta-sigma modulator, signed PCM in -> 1-bit PDM out.
// Samples arrive over a valid/ready handshake into a double buffer (cur/next).
// Each sample drives the modulator for OSR PDM bit periods.
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   en             modulator enable (divider, accumulator, sample counter run)
//   pcm_data       signed sample, DATA_W bits
//   pcm_valid      pcm_data valid
//   pcm_ready      sample slot (next buffer) free
//   pdm_out        PDM bit to amplifier
//   pdm_tick       one-clk pulse per PDM bit period
//   amp_sd_n       amplifier enable, follows en one clk later
//   underrun       sticky, a sample boundary found no sample buffered
//   underrun_clr   clears underrun (wins over a simultaneous set)
module pcm_2_pdm #(
   parameter int unsigned INPUT_FREQ = 100000000,
   parameter int unsigned PDM_FREQ   = 2400000,
   parameter int unsigned OSR        = 50,
   parameter int unsigned DATA_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DATA_W-1:0] pcm_data,
   input  logic              pcm_valid,
   output logic              pcm_ready,
   output logic              pdm_out,
   output logic              pdm_tick,
   output logic              amp_sd_n,
   output logic              underrun,
   input  logic              underrun_clr
);

   localparam int unsigned DIV    = INPUT_FREQ / PDM_FREQ;
   localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned SAMP_W = $clog2(OSR);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OSR - 1);
   // Adding 2^(DATA_W-1) modulo 2^DATA_W is an MSB flip.
   localparam logic [DATA_W-1:0] OFFSET    = {1'b1, {(DATA_W-1){1'b0}}};

   logic [DIV_W-1:0]  div_cnt;
   logic [SAMP_W-1:0] samp_cnt;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] cur;
   logic [DATA_W-1:0] nxt;
   logic              next_full;

   logic              capture;
   logic              boundary;
   logic              next_full_d;
   logic [DATA_W-1:0] u;
   logic [DATA_W:0]   sum;

   // Handshake, sample boundary and modulator adder.
   always_comb begin
      capture  = pcm_valid && pcm_ready;
      boundary = en && pdm_tick && (samp_cnt == SAMP_LAST);
      u        = cur ^ OFFSET;
      sum      = {1'b0, acc} + {1'b0, u};
      // A boundary load consumes the old next; a same-clk capture refills it.
      next_full_d = next_full;
      if (boundary && next_full) next_full_d = 1'b0;
      if (capture)               next_full_d = 1'b1;
   end

   // PDM bit-rate divider; pdm_tick is registered so it lands DIV clks after en rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt  <= '0;
         pdm_tick <= 1'b0;
      end else if (!en) begin
         div_cnt  <= '0;
         pdm_tick <= 1'b0;
      end else begin
         pdm_tick <= (div_cnt == DIV_LAST);
         div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      end
   end

   // Delta-sigma accumulator and sample counter, advanced once per tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         samp_cnt <= '0;
         pdm_out  <= 1'b0;
      end else if (!en) begin
         acc      <= '0;
         samp_cnt <= '0;
         pdm_out  <= 1'b0;
      end else if (pdm_tick) begin
         acc      <= sum[DATA_W-1:0];
         pdm_out  <= sum[DATA_W];
         samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + SAMP_W'(1);
      end
   end

   // Double buffer: capture into next, load into cur at sample boundaries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nxt       <= '0;
         cur       <= '0;
         next_full <= 1'b0;
         pcm_ready <= 1'b1;
      end else begin
         if (capture)              nxt <= pcm_data;
         if (boundary && next_full) cur <= nxt;
         next_full <= next_full_d;
         pcm_ready <= !next_full_d;
      end
   end

   // Amplifier enable and sticky underrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         amp_sd_n <= 1'b0;
         underrun <= 1'b0;
      end else begin
         amp_sd_n <= en;
         if (underrun_clr)                underrun <= 1'b0;
         else if (boundary && !next_full) underrun <= 1'b1;
      end
   end

endmodule
